// File: rtl/sig_shaper.sv
// Level shaper: queues requested output levels in a small FIFO and replays them
// on sig_out, holding every change for at least MIN_HOLD+1 clock edges.
module sig_shaper #(
  parameter int unsigned MIN_HOLD = 4,
  parameter int unsigned DEPTH    = 4
) (
  input  logic p_clk_in,
  input  logic p_rst,
  input  logic lvl_in,
  input  logic lvl_valid,
  output logic lvl_ready,
  output logic sig_out,
  output logic busy,
  output logic dbg_state
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Handshake: a request transfers on a rising edge where lvl_valid and
  // lvl_ready are both high; lvl_ready depends only on FIFO fullness and
  // reset, never on lvl_valid, so the producer may hold a request pending.

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            sig_q, sig_d;
  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            full, empty, push, pop, head;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign lvl_ready = !full && !p_rst;
  assign push      = lvl_valid && lvl_ready;
  assign head      = mem_q[rd_ptr_q];
  assign sig_out   = sig_q;
  assign busy      = (state_q == HOLD) || !empty;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          // A head equal to the current level is consumed without a hold.
          if (head != sig_q) begin
            sig_d   = head;
            cnt_d   = 8'(MIN_HOLD - 1);
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else               state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge p_clk_in) begin
    if (p_rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      sig_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage needs no reset: entries are only read behind a non-zero count.
  always_ff @(posedge p_clk_in) begin
    if (push) mem_q[wr_ptr_q] <= lvl_in;
  end

endmodule

// File: tb/tb_sig_shaper.sv
// Bench for sig_shaper: directed scenarios plus randomized traffic, checked
// against a time-based model (level queue plus earliest-next-pop edge).
module tb_sig_shaper;

  localparam int MIN_HOLD = 4;
  localparam int DEPTH    = 4;

  logic p_clk_in = 1'b0;
  logic p_rst    = 1'b1;
  logic lvl_in   = 1'b0;
  logic lvl_valid = 1'b0;
  logic lvl_ready, sig_out, busy, dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  sig_shaper #(.MIN_HOLD(MIN_HOLD), .DEPTH(DEPTH)) dut (
    .p_clk_in (p_clk_in),
    .p_rst    (p_rst),
    .lvl_in   (lvl_in),
    .lvl_valid(lvl_valid),
    .lvl_ready(lvl_ready),
    .sig_out  (sig_out),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 p_clk_in = ~p_clk_in;

  // ---------------- reference model ----------------
  logic m_q[$];      // pending levels
  logic m_out = 1'b0;
  int   m_n    = 0;  // index of the next edge
  int   m_last = -1; // index of the edge just taken
  int   m_next = 0;  // earliest edge at which a pop may occur

  function automatic logic exp_hold();
    return (m_last < m_next - 1);
  endfunction
  function automatic logic exp_busy();
    return (m_q.size() != 0) || exp_hold();
  endfunction
  function automatic logic exp_ready();
    return !p_rst && (m_q.size() < DEPTH);
  endfunction

  // Advance the model using the inputs presented before the edge, then take
  // the edge and settle 1 time unit.
  task automatic tick();
    logic acc;
    logic v;
    if (p_rst) begin
      m_q.delete();
      m_out  = 1'b0;
      m_next = 0;
    end else begin
      acc = lvl_valid && (m_q.size() < DEPTH);
      if (m_q.size() > 0 && m_n >= m_next) begin
        v = m_q.pop_front();
        if (v != m_out) begin
          m_out  = v;
          m_next = m_n + MIN_HOLD + 1;
        end else begin
          m_next = m_n + 1;
        end
      end
      if (acc) m_q.push_back(lvl_in);
    end
    @(posedge p_clk_in);
    #1;
    m_last = m_n;
    m_n++;
  endtask

  task automatic do_reset();
    p_rst = 1'b1; lvl_valid = 1'b0;
    tick();
    p_rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    p_rst = 1'b1; lvl_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (sig_out !== 1'b0 || busy !== 1'b0 || lvl_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: sig_out=%b busy=%b lvl_ready=%b required 0 0 0", sig_out, busy, lvl_ready);
      end
    end
    p_rst = 1'b0;
    #1;
    n_checks++;
    if (sig_out !== 1'b0 || busy !== 1'b0 || lvl_ready !== 1'b1 || dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: sig_out=%b busy=%b lvl_ready=%b state=%b required 0 0 1 0",
               sig_out, busy, lvl_ready, dbg_state);
    end
  endtask

  task automatic test_single();
    do_reset();
    lvl_in = 1'b1; lvl_valid = 1'b1;
    tick(); // E0
    lvl_valid = 1'b0;
    n_checks++;
    if (sig_out !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_e0: sig_out=%b busy=%b required 0 1", sig_out, busy);
    end
    for (int e = 1; e <= 6; e++) begin
      tick();
      n_checks++;
      if (sig_out !== 1'b1 || busy !== (e < 5)) begin
        n_fail++;
        $display("FAIL single_e%0d: sig_out=%b busy=%b required 1 %b", e, sig_out, busy, (e < 5));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic pat[3] = '{1'b1, 1'b0, 1'b1};
    logic want;
    do_reset();
    for (int e = 0; e <= 13; e++) begin
      lvl_valid = (e < 3);
      lvl_in    = (e < 3) ? pat[e] : 1'b0;
      tick();
      want = (e >= 1 && e <= 5) || (e >= 11);
      n_checks++;
      if (sig_out !== want || sig_out !== m_out) begin
        n_fail++;
        $display("FAIL b2b_e%0d: sig_out=%b required %b (model %b)", e, sig_out, want, m_out);
      end
    end
  endtask

  task automatic test_full();
    logic pat[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int guard;
    do_reset();
    lvl_in = 1'b1; lvl_valid = 1'b1;
    tick(); // E0
    lvl_valid = 1'b0;
    tick(); // E1: sig_out rises, hold begins
    for (int k = 0; k < 5; k++) begin
      lvl_in = pat[k]; lvl_valid = 1'b1;
      tick(); // E2..E6
      n_checks++;
      if (lvl_ready !== exp_ready() || sig_out !== m_out) begin
        n_fail++;
        $display("FAIL full_push%0d: lvl_ready=%b sig_out=%b required %b %b",
                 k, lvl_ready, sig_out, exp_ready(), m_out);
      end
      if (k == 3) begin
        n_checks++;
        if (lvl_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL full_ready: lvl_ready=%b required 0", lvl_ready);
        end
      end
    end
    lvl_valid = 1'b0;
    guard = 0;
    while (busy === 1'b1 && guard < 60) begin
      tick();
      guard++;
    end
    n_checks++;
    if (guard >= 60 || sig_out !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain: sig_out=%b busy=%b cycles=%0d required 1 0 <60", sig_out, busy, guard);
    end
  endtask

  task automatic test_redundant();
    do_reset();
    lvl_in = 1'b0; lvl_valid = 1'b1;
    tick(); // E0
    lvl_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL redundant_push: busy=%b required 1", busy);
    end
    tick(); // E1
    n_checks++;
    if (sig_out !== 1'b0 || busy !== 1'b0 || dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL redundant_pop: sig_out=%b busy=%b state=%b required 0 0 0", sig_out, busy, dbg_state);
    end
  endtask

  task automatic test_reset_mid();
    logic pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int bad;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      lvl_in = pat[k]; lvl_valid = 1'b1;
      tick();
    end
    lvl_valid = 1'b0;
    n_checks++;
    if (dbg_state !== 1'b1 || sig_out !== 1'b1 || busy !== 1'b1 || lvl_ready !== exp_ready()) begin
      n_fail++;
      $display("FAIL mid_setup: state=%b sig_out=%b busy=%b lvl_ready=%b required 1 1 1 %b",
               dbg_state, sig_out, busy, lvl_ready, exp_ready());
    end
    p_rst = 1'b1;
    tick();
    p_rst = 1'b0;
    n_checks++;
    if (sig_out !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: sig_out=%b busy=%b required 0 0", sig_out, busy);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sig_out !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mid_quiet: %0d cycles with activity after reset, required 0", bad);
    end
  endtask

  task automatic test_random();
    int errs;
    int first_bad;
    errs = 0;
    first_bad = -1;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      p_rst     = ($urandom_range(0, 79) == 0);
      lvl_valid = ($urandom_range(0, 99) < 60);
      lvl_in    = $urandom_range(0, 1);
      tick();
      lvl_valid = 1'b0;
      if (sig_out !== m_out || busy !== exp_busy() || dbg_state !== exp_hold()
          || lvl_ready !== exp_ready()) begin
        errs++;
        if (first_bad < 0) begin
          first_bad = i;
          $display("FAIL random_cycle%0d: sig_out=%b busy=%b state=%b ready=%b required %b %b %b %b",
                   i, sig_out, busy, dbg_state, lvl_ready, m_out, exp_busy(), exp_hold(), exp_ready());
        end
      end
    end
    p_rst = 1'b0;
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL random_total: %0d mismatching cycles, required 0", errs);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_redundant();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
